// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage: valid/ack imem read, stall to PC, fault on error/timeout/misalign
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ia,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic        Stall
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misaligned;

  assign misaligned = |ia[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fault_d = fault_q;
    cnt_d   = 8'h0;
    case (state_q)
      S_REQ: begin
        if (misaligned) begin
          state_d = S_VALID;
          instr_d = NOP_WORD;
          fault_d = 1'b1;
        end else if (imem_ack) begin
          // A same-cycle ack beats the timeout check below.
          state_d = S_VALID;
          instr_d = imem_err ? NOP_WORD : imem_rdata;
          fault_d = imem_err;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_VALID;
          instr_d = NOP_WORD;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_VALID: state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req    = (state_q == S_REQ) && !misaligned;
  assign imem_addr   = {ia[31:2], 2'b00};
  assign instr       = instr_q;
  assign fetch_fault = fault_q;
  assign instr_valid = (state_q == S_VALID);
  assign Stall       = (state_q != S_VALID);

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q  <= 32'h0;
      stall_cycles_q <= 32'h0;
    end else begin
      if (state_q == S_VALID && fetch_count_q != 32'hFFFFFFFF)
        fetch_count_q <= fetch_count_q + 32'd1;
      if (state_q == S_REQ && stall_cycles_q != 32'hFFFFFFFF)
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed bench for ifetch with a transaction-level fetch model
module tb_ifetch;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ia;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        Stall;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, stall_cycles;
`endif

  ifetch #(.TIMEOUT(TIMEOUT), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .ia(ia),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault), .Stall(Stall)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          exp_en = 1'b0;
  logic        exp_req, exp_valid, exp_stall, exp_fault;
  logic [31:0] exp_addr, exp_instr;

  logic [31:0] m_instr;
  logic        m_fault;

  logic [31:0] f_instr0, f_addr0, v_instr;
  logic        f_req0, f_fault0, f_stall0, v_fault, v_stall, any_req;
  int          req_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_en) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("imem_addr", imem_addr, exp_addr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
      chk("Stall", {31'b0, Stall}, {31'b0, exp_stall});
      chk("instr", instr, exp_instr);
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    end
  end

  // lat: REQ cycle on which memory acks (0 = never). Called at posedge+1.
  task automatic fetch(input logic [31:0] a, input int lat, input bit err,
                       input logic [31:0] d, input bit ack_in_valid);
    bit mis, ok;
    int nreq;
    mis  = |a[1:0];
    ok   = !mis && lat >= 1 && lat <= TIMEOUT;
    nreq = mis ? 1 : (ok ? lat : TIMEOUT);
    req_cnt = 0;
    any_req = 1'b0;
    for (int k = 1; k <= nreq; k++) begin
      ia         = a;
      imem_ack   = ok && (k == lat);
      imem_err   = imem_ack ? err : 1'b1;
      imem_rdata = imem_ack ? d : (32'hDEAD0000 + k);
      exp_req   = !mis;
      exp_addr  = {a[31:2], 2'b00};
      exp_valid = 1'b0;
      exp_stall = 1'b1;
      exp_instr = m_instr;
      exp_fault = m_fault;
      @(negedge clk);
      if (k == 1) begin
        f_req0   = imem_req;
        f_addr0  = imem_addr;
        f_instr0 = instr;
        f_fault0 = fetch_fault;
        f_stall0 = Stall;
      end
      req_cnt += int'(Stall);
      any_req |= imem_req;
      @(posedge clk);
      #1;
    end
    m_instr    = (ok && !err) ? d : NOP;
    m_fault    = !(ok && !err);
    imem_ack   = ack_in_valid;
    imem_err   = 1'b0;
    imem_rdata = 32'h0BADF00D;
    exp_req   = 1'b0;
    exp_valid = 1'b1;
    exp_stall = 1'b0;
    exp_instr = m_instr;
    exp_fault = m_fault;
    @(negedge clk);
    v_instr = instr;
    v_fault = fetch_fault;
    v_stall = Stall;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
  endtask

  // Two REQ cycles of an access that would need 5, with reset raised in the second.
  task automatic reset_mid(input logic [31:0] a);
    for (int k = 1; k <= 2; k++) begin
      ia         = a;
      imem_ack   = 1'b0;
      imem_err   = 1'b0;
      imem_rdata = 32'h0;
      reset      = (k == 2);
      exp_req   = 1'b1;
      exp_addr  = {a[31:2], 2'b00};
      exp_valid = 1'b0;
      exp_stall = 1'b1;
      exp_instr = m_instr;
      exp_fault = m_fault;
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    m_instr = 32'h0;
    m_fault = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    ia         = 32'h80000000;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_instr = 32'h0;
    m_fault = 1'b0;
    exp_en  = 1'b1;

    fetch(32'h80000000, 1, 1'b0, 32'h8C010004, 1'b0);
    chk("rst_req", {31'b0, f_req0}, 32'd1);
    chk("rst_stall", {31'b0, f_stall0}, 32'd1);
    chk("rst_instr", f_instr0, 32'h0);
    chk("rst_fault", {31'b0, f_fault0}, 32'd0);
    chk("t1_addr", f_addr0, 32'h80000000);
    chk("t1_instr", v_instr, 32'h8C010004);
    chk("t1_stall_valid", {31'b0, v_stall}, 32'd0);
    chk("t1_req_cycles", req_cnt, 32'd1);

    fetch(32'h80000004, 3, 1'b0, 32'h00221820, 1'b0);
    chk("t1_stall_after", {31'b0, f_stall0}, 32'd1);
    chk("t2_req_cycles", req_cnt, 32'd3);
    chk("t2_instr", v_instr, 32'h00221820);

    fetch(32'h80000008, 2, 1'b1, 32'h12345678, 1'b1);
    chk("t3_err_instr", v_instr, 32'h00000000);
    chk("t3_err_fault", {31'b0, v_fault}, 32'd1);

    fetch(32'h8000000C, 1, 1'b0, 32'hAABBCCDD, 1'b0);
    chk("t4_after_err_fault", {31'b0, v_fault}, 32'd0);
    chk("t4_after_err_instr", v_instr, 32'hAABBCCDD);

    fetch(32'h80000010, 0, 1'b0, 32'h55555555, 1'b0);
    chk("t5_timeout_cycles", req_cnt, 32'd16);
    chk("t5_timeout_fault", {31'b0, v_fault}, 32'd1);

    fetch(32'h80000014, 16, 1'b0, 32'hCAFEBABE, 1'b0);
    chk("t6_lastack_cycles", req_cnt, 32'd16);
    chk("t6_lastack_fault", {31'b0, v_fault}, 32'd0);
    chk("t6_lastack_instr", v_instr, 32'hCAFEBABE);

    fetch(32'h80000006, 1, 1'b0, 32'h77777777, 1'b0);
    chk("t7_mis_req", {31'b0, any_req}, 32'd0);
    chk("t7_mis_cycles", req_cnt, 32'd1);
    chk("t7_mis_fault", {31'b0, v_fault}, 32'd1);

    fetch(32'h80000018, 15, 1'b0, 32'h11112222, 1'b0);
    fetch(32'h80000001, 1, 1'b0, 32'h99999999, 1'b0);
    fetch(32'h8000001C, 1, 1'b0, 32'h11112222, 1'b0);

    reset_mid(32'h80000020);
    fetch(32'h80000020, 5, 1'b0, 32'h33334444, 1'b0);
    chk("t8_rst_req", {31'b0, f_req0}, 32'd1);
    chk("t8_rst_instr", f_instr0, 32'h0);
    chk("t8_rst_fault", {31'b0, f_fault0}, 32'd0);
    chk("t8_cycles", req_cnt, 32'd5);
    chk("t8_instr", v_instr, 32'h33334444);

    fetch(32'h80000024, 4, 1'b1, 32'h44445555, 1'b0);
    fetch(32'h80000028, 2, 1'b0, 32'h66667777, 1'b0);

    exp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
Instruction fetch stage that sits directly downstream of the program counter in the single-cycle MIPS core. It takes the current instruction address `ia`, runs a valid/ack read on the instruction memory port, and presents the fetched word to decode. It asserts `Stall` back to the PC until the word is available, so variable memory latency is hidden from the rest of the core. Bus errors and timeouts are reported as a fetch fault, which the exception logic uses to select the ILLOP handler.

Parameters:
TIMEOUT, 16, maximum cycles in REQ without `imem_ack` before a fault is declared (legal range 2..255).
NOP_WORD, 32'h00000000, value driven on `instr` for a faulted fetch.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
ia  input  32  current instruction address from the PC; stable while `Stall`=1.
imem_req  output  1  read request to instruction memory.
imem_addr  output  32  read address; equals `ia` with bits [1:0] forced to 0.
imem_ack  input  1  memory completion strobe; `imem_rdata`/`imem_err` are valid in the same cycle.
imem_rdata  input  32  read data.
imem_err  input  1  bus error qualifier, sampled only with `imem_ack`.
instr  output  32  registered fetched instruction.
instr_valid  output  1  `instr` is valid for execution this cycle.
fetch_fault  output  1  this cycle's fetch failed (bus error, timeout or misaligned address).
Stall  output  1  hold the PC; high whenever `instr_valid`=0.

Behaviour:
- State machine states: REQ, VALID. State is registered. `imem_req`=(state==REQ), `instr_valid`=(state==VALID), `Stall`=~instr_valid. There is no combinational path from memory inputs to `Stall`.
- Reset (synchronous, sampled on the `clk` edge):
  - state←REQ, `instr`←0, `fetch_fault`←0, timeout counter←0.
  - Outputs in the first post-reset cycle: `imem_req`=1, `Stall`=1, `instr_valid`=0. The PC reset and fetch reset take effect on the same edge, so the first request carries 0x80000000.
- REQ:
  - `imem_req`=1 and `imem_addr` are held stable until `imem_ack`.
  - On `imem_ack`=1 and `imem_err`=0: `instr`←`imem_rdata`, `fetch_fault`←0, go to VALID.
  - On `imem_ack`=1 and `imem_err`=1: `instr`←NOP_WORD, `fetch_fault`←1, go to VALID.
  - Each cycle without ack, the counter increments. When the counter reaches TIMEOUT-1 with no ack, treat it as an error: NOP_WORD, fault, go to VALID. If ack arrives in the same cycle the counter reaches TIMEOUT-1, the ack wins.
  - The counter clears on leaving REQ.
- Misaligned address (`ia[1:0]`≠0): detected at REQ entry. No request is issued (`imem_req` forced 0). Go to VALID next cycle with NOP_WORD and `fetch_fault`=1.
- VALID:
  - Lasts exactly one cycle; `Stall`=0, so the PC loads its next address at the end of this cycle.
  - Then go unconditionally to REQ.
  - `imem_ack` received in VALID is ignored; memory must not ack without a request.
- Latency:
  - Minimum 2 cycles per instruction (ack in the first REQ cycle, then VALID).
  - General case: N REQ cycles + 1.
- `instr` and `fetch_fault` hold their values outside VALID; downstream qualifies with `instr_valid`.
- Reset mid-request: the FSM returns to REQ. Memory is required to drop any outstanding transaction on `reset`.

Optional Feature:
IFETCH_PERF_EN: adds output ports `fetch_count[31:0]` and `stall_cycles[31:0]`, both reset to 0.
- `fetch_count` increments once per VALID cycle.
- `stall_cycles` increments once per REQ cycle.
- Both saturate at 32'hFFFFFFFF.

When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, `ia`=0x80000000, memory acks in the first REQ cycle with 0x8C010004 -> `imem_addr`=0x80000000; `instr`=0x8C010004 and `instr_valid`=1 on cycle 2; `Stall` pattern 1,0,1.
- Memory latency 3 cycles, rdata 0x00221820 -> `Stall`=1 for 3 cycles, `instr_valid` for 1 cycle, `imem_addr` stable throughout REQ.
- Ack with `imem_err`=1 -> `instr`=0x00000000, `fetch_fault`=1 for the single VALID cycle, next fetch proceeds normally.
- No ack with TIMEOUT=16 -> after 16 REQ cycles, VALID with `fetch_fault`=1; ack at REQ cycle 16 instead -> normal data, no fault.
- `ia`=0x80000006 -> `imem_req` never asserted; VALID next cycle with `fetch_fault`=1.
- Reset asserted during REQ cycle 2 of a 5-cycle access -> next cycle state REQ, `instr`=0, `fetch_fault`=0, no VALID from the aborted access.
